// File: rtl/mux_rr_stream.sv
// mux_rr_stream: N-to-1 stream multiplexer with a registered output stage.
// A channel is chosen either by an explicit select (fixed mode) or by a
// round-robin arbiter (RR mode). The winner is then loaded into one output
// register that has a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   i_mode        0 = fixed select, 1 = round-robin
//   i_sel         channel index used in fixed mode
//   i_valid       per-channel valid (bit k = channel k)
//   i_data        channel k at [k*BW +: BW]
//   o_ready       per-channel ready (combinational, at most one bit set)
//   o_valid       output register holds a word
//   o_data        registered output word
//   o_ch          source channel of o_data
//   i_ready       downstream ready
module mux_rr_stream #(
  parameter int unsigned BW = 8,
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_mode,
  input  logic [SW-1:0]     i_sel,
  input  logic [N-1:0]      i_valid,
  input  logic [N*BW-1:0]   i_data,
  output logic [N-1:0]      o_ready,
  output logic              o_valid,
  output logic [BW-1:0]     o_data,
  output logic [SW-1:0]     o_ch,
  input  logic              i_ready
);

  localparam logic [SW-1:0] LAST_CH = SW'(N - 1);

  logic              valid_q, valid_d;
  logic [BW-1:0]     data_q,  data_d;
  logic [SW-1:0]     ch_q,    ch_d;
  logic [SW-1:0]     ptr_q,   ptr_d;

  logic              ld;
  logic              grant_valid;
  logic [SW-1:0]     grant;
  int unsigned       rr_idx;

  // The output register can take a word when empty or when drained this cycle
  assign ld = !valid_q || i_ready;

  // Grant selection. The RR search runs from the farthest candidate to the
  // nearest one, so the last hit is the first channel after ptr.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    rr_idx      = 0;
    if (!i_mode) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (i_sel == SW'(k) && i_valid[k]) begin
          grant_valid = 1'b1;
          grant       = SW'(k);
        end
      end
    end else begin
      for (int unsigned off = N; off >= 1; off--) begin
        rr_idx = 32'(ptr_q) + off;
        if (rr_idx >= N) begin
          rr_idx = rr_idx - N;
        end
        if (i_valid[rr_idx]) begin
          grant_valid = 1'b1;
          grant       = SW'(rr_idx);
        end
      end
    end
  end

  // One-hot ready toward the granted producer, suppressed during reset
  always_comb begin
    o_ready = '0;
    for (int unsigned k = 0; k < N; k++) begin
      o_ready[k] = !i_rst && ld && grant_valid && (grant == SW'(k));
    end
  end

  // Next-state for the output register and the round-robin pointer
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (ld) begin
      valid_d = grant_valid;
      if (grant_valid) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (grant == SW'(k)) begin
            data_d = i_data[k*BW +: BW];
          end
        end
        ch_d = grant;
        if (i_mode) begin
          ptr_d = grant;
        end
      end
    end
  end

  // ptr resets to the last channel so that channel 0 has first priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= LAST_CH;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_ch    = ch_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb_mux_rr_stream: testbench for mux_rr_stream.
// The N=4 instance is driven by directed and random stimulus. A reference
// model predicts o_ready and pushes each expected output word into a queue,
// and a monitor pops from that queue and compares against the DUT outputs.
// An N=3 instance gets a short directed sequence for the
// non-power-of-two cases.
module tb_mux_rr_stream;

  localparam int BW  = 8;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int N3  = 3;
  localparam int SW3 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance signals
  logic            rst, mode, irdy, ovalid;
  logic [SW-1:0]   sel, och;
  logic [N-1:0]    valid, ordy;
  logic [N*BW-1:0] data;
  logic [BW-1:0]   odata;

  // N=3 instance signals
  logic             rst3, mode3, irdy3, ovalid3;
  logic [SW3-1:0]   sel3, och3;
  logic [N3-1:0]    valid3, ordy3;
  logic [N3*BW-1:0] data3;
  logic [BW-1:0]    odata3;

  mux_rr_stream #(.BW(BW), .N(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_sel(sel), .i_valid(valid),
    .i_data(data), .o_ready(ordy), .o_valid(ovalid), .o_data(odata),
    .o_ch(och), .i_ready(irdy)
  );

  mux_rr_stream #(.BW(BW), .N(N3)) dut3 (
    .i_clk(clk), .i_rst(rst3), .i_mode(mode3), .i_sel(sel3), .i_valid(valid3),
    .i_data(data3), .o_ready(ordy3), .o_valid(ovalid3), .o_data(odata3),
    .o_ch(och3), .i_ready(irdy3)
  );

  typedef struct {
    logic [BW-1:0] d;
    int            ch;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   occ_m;
  int   ptr_m;

  localparam logic [N*BW-1:0]  SWEEP = {8'h13, 8'h12, 8'h11, 8'h10};
  localparam logic [N3*BW-1:0] D3    = {8'hA2, 8'hA1, 8'hA0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First requesting channel strictly after p, wrapping around
  function automatic int rr_pick(input int p, input logic [N-1:0] v);
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (p + off) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Predict this cycle's ready, and the word that the coming edge captures
  task automatic model_step();
    int           g;
    bit           ld;
    logic [N-1:0] er;
    ld = (occ_m == 0) || irdy;
    if (mode) g = rr_pick(ptr_m, valid);
    else      g = (int'(sel) < N && valid[sel]) ? int'(sel) : -1;
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    check("o_ready", 64'(ordy), 64'(er));
    if (ld) begin
      if (g >= 0) begin
        q.push_back('{d: data[g*BW +: BW], ch: g});
        occ_m = 1;
        if (mode) ptr_m = g;
      end else begin
        occ_m = 0;
      end
    end
  endtask

  task automatic cyc(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v,
                     input logic [N*BW-1:0] d, input logic r);
    @(negedge clk);
    mode = m; sel = s; valid = v; data = d; irdy = r;
    #2;
    model_step();
  endtask

  // Reset mid-stream, check the immediate effect, then release with all valid
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 4'hF;
    #2;
    check("rst o_valid", 64'(ovalid), 64'(0));
    check("rst o_data",  64'(odata),  64'(0));
    check("rst o_ch",    64'(och),    64'(0));
    check("rst o_ready", 64'(ordy),   64'(0));
    q.delete();
    occ_m = 0;
    ptr_m = N - 1;
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; valid = 4'hF; data = SWEEP; irdy = 1'b1;
    #2;
    check("first grant after reset", 64'(ordy), 64'(4'b0001));
    model_step();
  endtask

  // Monitor: compares the held word against the head of the scoreboard
  initial begin
    exp_t tmp;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("o_valid", 64'(ovalid), 64'(q.size() > 0));
        if (ovalid && q.size() > 0) begin
          check("o_data", 64'(odata), 64'(q[0].d));
          check("o_ch",   64'(och),   64'(q[0].ch));
          if (irdy) tmp = q.pop_front();
        end
      end
    end
  end

  initial begin
    rst = 1'b1; mode = 1'b1; sel = '0; valid = '0; data = '0; irdy = 1'b1;
    rst3 = 1'b1; mode3 = 1'b1; sel3 = '0; valid3 = '0; data3 = D3; irdy3 = 1'b1;
    occ_m = 0;
    ptr_m = N - 1;
    repeat (2) @(negedge clk);

    do_reset();
    // RR sweep over all channels
    repeat (8) cyc(1'b1, 2'd0, 4'hF, SWEEP, 1'b1);
    // RR skip: move ptr to 1, then only channels 1 and 3 request
    cyc(1'b1, 2'd0, 4'b0010, SWEEP, 1'b1);
    repeat (4) cyc(1'b1, 2'd0, 4'b1010, SWEEP, 1'b1);
    // Fixed mode on channel 2, then back to RR
    repeat (4) cyc(1'b0, 2'd2, 4'hF, SWEEP, 1'b1);
    repeat (3) cyc(1'b1, 2'd0, 4'hF, SWEEP, 1'b1);
    // Back-pressure for 3 cycles, then release
    repeat (3) cyc(1'b1, 2'd0, 4'hF, SWEEP, 1'b0);
    repeat (3) cyc(1'b1, 2'd0, 4'hF, SWEEP, 1'b1);
    // Reset with a word held
    do_reset();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      else cyc(1'($urandom), 2'($urandom), 4'($urandom), 32'($urandom),
               1'($urandom_range(0, 9) < 7));
    end

    // Idle the N=4 instance so that the held word drains
    cyc(1'b1, 2'd0, 4'h0, SWEEP, 1'b1);

    // N=3: RR wraps 0,1,2,0
    @(negedge clk);
    rst3 = 1'b0; mode3 = 1'b1; valid3 = 3'b111; irdy3 = 1'b1;
    #2;
    check("n3 ready ch0", 64'(ordy3), 64'(3'b001));
    @(negedge clk); #2;
    check("n3 ready ch1", 64'(ordy3), 64'(3'b010));
    check("n3 o_ch 0",    64'(och3),  64'(0));
    check("n3 o_data 0",  64'(odata3), 64'(8'hA0));
    @(negedge clk); #2;
    check("n3 ready ch2", 64'(ordy3), 64'(3'b100));
    check("n3 o_ch 1",    64'(och3),  64'(1));
    @(negedge clk); #2;
    check("n3 ready wrap", 64'(ordy3), 64'(3'b001));
    check("n3 o_ch 2",     64'(och3),  64'(2));
    // N=3: fixed select 3 is out of range, so there is no grant
    @(negedge clk);
    mode3 = 1'b0; sel3 = 2'd3;
    #2;
    check("n3 o_ch wrap 0",  64'(och3),    64'(0));
    check("n3 sel3 ready",   64'(ordy3),   64'(0));
    check("n3 sel3 o_valid", 64'(ovalid3), 64'(1));
    @(negedge clk); #2;
    check("n3 drained o_valid", 64'(ovalid3), 64'(0));
    check("n3 drained ready",   64'(ordy3),   64'(0));
    check("n3 o_data hold",     64'(odata3),  64'(8'hA0));

    @(negedge clk); #3;
    check("scoreboard empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
# mux_rr_stream

Parametrised N-to-1 stream multiplexer with a registered output and valid/ready handshakes on every channel. It is the sequential successor to the two-input combinational mux. It selects one of N input channels, either by an explicit select (fixed mode) or by a fair round-robin arbiter (RR mode), and presents the winner through a single output register. It sits between N producers and one shared consumer, for example a shared bus or a FIFO write port.

## Interface
Parameters:
- `BW`, 8, data width per channel
- `N`, 4, number of input channels (≥2, need not be a power of two)
- `SW`, `$clog2(N)`, select/channel-index width (derived, do not override)

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge
- `i_rst`  in  1  reset; one clock; asynchronous, active-high
- `i_mode`  in  1  0 = fixed select, 1 = round-robin
- `i_sel`  in  SW  channel index used in fixed mode
- `i_valid`  in  N  per-channel valid; bit k belongs to channel k
- `i_data`  in  N*BW  channel k occupies bits [k*BW +: BW]
- `o_ready`  out  N  per-channel ready; combinational
- `o_valid`  out  1  output register holds a word
- `o_data`  out  BW  registered output word
- `o_ch`  out  SW  index of the channel `o_data` came from
- `i_ready`  in  1  downstream ready

## Operation
- Load enable: `ld = !o_valid || i_ready`. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant, fixed mode (`i_mode`=0):
  - The candidate is `i_sel`.
  - The grant is valid iff `i_sel < N` and `i_valid[i_sel]`.
  - The `i_valid` bits of other channels are ignored.
- Grant, RR mode (`i_mode`=1):
  - Search starts at `(ptr+1) mod N` and proceeds upward with wrap-around.
  - The first channel with `i_valid` set wins.
  - If no bit is set, there is no grant.
- `o_ready[k] = !i_rst && ld && grant_valid && (grant == k)`. At most one bit is set, and no bit is set without a matching `i_valid`.
- Transfer on channel k happens when `i_valid[k] && o_ready[k]`. On the next edge:
  - `o_data` gets channel k's data.
  - `o_ch` gets k.
  - `o_valid` goes to 1.
  - In RR mode only, `ptr` gets k.
- When `ld` is set and there is no grant: `o_valid` goes to 0. `o_data` and `o_ch` hold their values.
- When `ld` is clear (the register is full and `i_ready` is 0): `o_valid`, `o_data` and `o_ch` hold, and all `o_ready` bits are 0.
- Round-robin pointer `ptr` (SW bits):
  - Updated only by an RR-mode transfer.
  - Fixed-mode transfers leave it unchanged.
  - It never holds a value ≥ N.
- Mode or select changes take effect in the same cycle's combinational grant. No state is flushed, and a word already in the output register is delivered unchanged.
- Producers must hold `i_data` stable while `i_valid` is high and `o_ready` is low. The block does not check this.

## Timing
- Reset values (asynchronous, immediate on assertion of `i_rst`):
  - `o_valid`=0, `o_data`=0, `o_ch`=0.
  - `ptr`=N-1, so channel 0 has first priority after reset.
  - `o_ready`=0 for as long as `i_rst` is high.
- Reset asserted mid-transfer discards the held word. No transfer completes in any cycle where `i_rst` is high at the edge.
- Latency: 1 cycle from input transfer to `o_valid`/`o_data`.
- Throughput: 1 word per cycle sustained while `i_ready`=1.
- Full back-pressure: when `i_ready`=0 and `o_valid`=1, all `o_ready` bits are 0 within the same cycle.
- Simultaneous output drain and input load in one cycle is required; no bubble may be inserted.
- RR fairness: with all N channels continuously valid and `i_ready`=1, the grant order after reset is 0,1,…,N-1,0,… Each channel waits at most N-1 grants.
- Non-power-of-two N:
  - The RR search wraps from N-1 to 0.
  - In fixed mode, `i_sel` ≥ N yields no grant and `o_ready`=0.

## Test plan
- Reset: assert `i_rst` mid-stream with `o_valid`=1 → `o_valid`, `o_data` and `o_ch` go to 0 immediately, `o_ready`=0; after release with `i_valid`=4'b1111 in RR mode, the first grant is channel 0.
- RR sweep (N=4, BW=8): `i_valid`=4'b1111, data = 8'h10+k, `i_ready`=1 → `o_data` sequence 10,11,12,13,10 starting 1 cycle after the first grant, with `o_valid` continuously high.
- RR skip: `i_valid`=4'b1010 with `ptr` at 1 → grant 3, then 1, then 3; `o_ready` never set on channels 0 or 2.
- Fixed mode: `i_mode`=0, `i_sel`=2, `i_valid`=4'b1111 → only channel 2 transfers and `o_ch`=2 every cycle; `ptr` is unchanged when `i_mode` returns to 1.
- Back-pressure: `i_ready`=0 for 3 cycles with `o_valid`=1 → `o_data` held, `o_ready`=0; on the cycle `i_ready` returns to 1, drain and load occur together with no bubble.
- Edge parameter N=3: fixed mode with `i_sel`=3 → `o_ready`=0 and `o_valid` falls after the drain; in RR mode, channel 2 is followed by channel 0.
